// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with run-time pattern, overlap select and saturating match counter.
// Optional compile-time feature SEQ_DET_MASK_EN adds a don't-care mask (mask_in) latched with the pattern.
//
// state       | meaning
// ------------|----------------------------------------------------------
// ST_FILLING  | fewer than PAT_W valid bits in history; no match possible
// ST_ARMED    | history holds PAT_W valid bits; each shift may match
module seq_detector_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i,
    input  logic             in_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] mask_in,
`endif
    input  logic             overlap,
    input  logic             count_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        ST_FILLING = 1'b0,
        ST_ARMED   = 1'b1
    } state_t;

    state_t            r_state;
    logic [PAT_W-1:0]  r_hist;
    logic [PAT_W-1:0]  r_pat;
    logic [FILL_W-1:0] r_fill;
    logic              r_out;
    logic [CNT_W-1:0]  r_cnt;

    logic [PAT_W-1:0]  w_hist_n;
    logic [FILL_W-1:0] w_fill_n;
    logic [PAT_W-1:0]  w_diff;
    logic              w_shift;
    logic              w_match;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]  r_mask;
    assign w_diff = (w_hist_n ^ r_pat) & r_mask;
`else
    assign w_diff = w_hist_n ^ r_pat;
`endif

    assign w_shift  = in_valid && !load;
    assign w_hist_n = {r_hist[PAT_W-2:0], i};
    assign w_fill_n = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
    assign w_match  = w_shift && (w_fill_n == FILL_FULL) && (w_diff == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_FILLING;
            r_hist  <= '0;
            r_pat   <= '0;
            r_fill  <= '0;
            r_out   <= 1'b0;
            r_cnt   <= '0;
`ifdef SEQ_DET_MASK_EN
            r_mask  <= '1;
`endif
        end else begin
            r_out <= w_match;

            if (load) begin
                r_pat   <= pattern_in;
`ifdef SEQ_DET_MASK_EN
                r_mask  <= mask_in;
`endif
                r_fill  <= '0;
                r_state <= ST_FILLING;
            end else if (in_valid) begin
                r_hist <= w_hist_n;
                // Non-overlapping mode discards every bit of the completed match
                if (w_match && !overlap) begin
                    r_fill  <= '0;
                    r_state <= ST_FILLING;
                end else begin
                    r_fill  <= w_fill_n;
                    r_state <= (w_fill_n == FILL_FULL) ? ST_ARMED : ST_FILLING;
                end
            end

            if (count_clr)
                r_cnt <= w_match ? CNT_W'(1) : '0;
            else if (w_match && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out         = r_out;
    assign match_count = r_cnt;
    assign armed       = (r_state == ST_ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: main instance (CNT_W=8) plus a CNT_W=2 instance for saturation.
// Build with SEQ_DET_MASK_EN defined to also exercise the mask feature.
module tb_seq_detector_param;

    localparam int PAT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             i;
    logic             in_valid;
    logic             load;
    logic [PAT_W-1:0] pattern_in;
    logic [PAT_W-1:0] mask_in;
    logic             overlap;
    logic             count_clr;
    logic             out, out_s;
    logic [7:0]       match_count;
    logic [1:0]       match_count_s;
    logic             armed, armed_s;

    int n_tests = 0;
    int n_fail  = 0;

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(8)) u_dut (
        .clock(clock), .reset(reset), .i(i), .in_valid(in_valid), .load(load),
        .pattern_in(pattern_in),
`ifdef SEQ_DET_MASK_EN
        .mask_in(mask_in),
`endif
        .overlap(overlap), .count_clr(count_clr),
        .out(out), .match_count(match_count), .armed(armed)
    );

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .i(i), .in_valid(in_valid), .load(load),
        .pattern_in(pattern_in),
`ifdef SEQ_DET_MASK_EN
        .mask_in(mask_in),
`endif
        .overlap(overlap), .count_clr(count_clr),
        .out(out_s), .match_count(match_count_s), .armed(armed_s)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs are read 1 ns after the next edge.
    task automatic step();
        @(posedge clock);
        #1;
        reset     = 1'b0;
        load      = 1'b0;
        count_clr = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic send(input logic b);
        i = b; in_valid = 1'b1;
        step();
    endtask

    task automatic idle(input logic b);
        i = b; in_valid = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
    endtask

    task automatic do_load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m,
                           input logic vb, input logic b);
        load = 1'b1; pattern_in = p; mask_in = m; in_valid = vb; i = b;
        step();
    endtask

    logic [6:0] stream1;
    logic [6:0] exp1_ov;
    logic [6:0] exp1_no;
    logic [2:0] sat_exp [10];

    initial begin
        reset = 1'b1; i = 1'b0; in_valid = 1'b0; load = 1'b0;
        pattern_in = '0; mask_in = '1; overlap = 1'b1; count_clr = 1'b0;
        #1;
        step();
        check("rst_out", out, 0);
        check("rst_cnt", match_count, 0);
        check("rst_armed", armed, 0);

        // Test 1: overlapping; bit offered during load must be discarded
        stream1 = 7'b1011011;   // sent MSB first
        exp1_ov = 7'b0001001;
        exp1_no = 7'b0001000;
        overlap = 1'b1;
        do_load(4'b1011, 4'b1111, 1'b1, 1'b1);
        check("t1_load_out", out, 0);
        for (int k = 0; k < 7; k++) begin
            send(stream1[6-k]);
            check($sformatf("t1_out_b%0d", k+1), out, exp1_ov[6-k]);
            if (k == 2) check("t1_armed_b3", armed, 0);
            if (k == 3) check("t1_armed_b4", armed, 1);
        end
        check("t1_cnt", match_count, 2);
        idle(1'b1);
        check("t1_out_idle", out, 0);

        // Test 2: non-overlapping
        do_reset();
        overlap = 1'b0;
        do_load(4'b1011, 4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            send(stream1[6-k]);
            check($sformatf("t2_out_b%0d", k+1), out, exp1_no[6-k]);
            if (k == 3) check("t2_armed_after_match", armed, 0);
            if (k == 6) check("t2_armed_b7", armed, 0);
        end
        send(1'b1);
        check("t2_armed_b8", armed, 1);
        check("t2_out_b8", out, 0);
        check("t2_cnt", match_count, 1);

        // Test 3: idle cycles with toggling data are ignored
        do_reset();
        overlap = 1'b1;
        do_load(4'b1011, 4'b1111, 1'b0, 1'b0);
        send(1'b1);
        send(1'b0);
        idle(1'b1); check("t3_idle1", out, 0);
        idle(1'b0); check("t3_idle2", out, 0);
        idle(1'b1); check("t3_idle3", out, 0);
        check("t3_armed_idle", armed, 0);
        send(1'b1); check("t3_out_b3", out, 0);
        send(1'b1); check("t3_out_b4", out, 1);
        check("t3_cnt", match_count, 1);

        // Test 4: reset mid-stream clears history, fill, count and pattern (pattern 0 afterwards)
        do_load(4'b1011, 4'b1111, 1'b0, 1'b0);
        send(1'b1); send(1'b0); send(1'b1);
        do_reset();
        check("t4_out", out, 0);
        check("t4_cnt", match_count, 0);
        check("t4_armed", armed, 0);
        send(1'b1); check("t4_out_b1", out, 0);
        check("t4_armed_b1", armed, 0);
        send(1'b0); send(1'b0);
        check("t4_armed_b3", armed, 0);
        send(1'b0);
        check("t4_armed_b4", armed, 1);
        check("t4_out_b4", out, 0);
        send(1'b0);
        check("t4_zero_pat_match", out, 1);
        check("t4_cnt", match_count, 1);

        // Test 5: saturation on the CNT_W=2 instance
        do_reset();
        overlap = 1'b1;
        do_load(4'b1111, 4'b1111, 1'b0, 1'b0);
        sat_exp = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
        for (int k = 0; k < 10; k++) begin
            send(1'b1);
            check($sformatf("t5_sat_cnt_b%0d", k+1), match_count_s, sat_exp[k]);
        end
        check("t5_main_cnt", match_count, 7);
        count_clr = 1'b1;
        send(1'b1);
        check("t5_clr_with_match_sat", match_count_s, 1);
        check("t5_clr_with_match_main", match_count, 1);
        check("t5_clr_out", out, 1);
        count_clr = 1'b1;
        idle(1'b1);
        check("t5_clr_no_match", match_count, 0);
        check("t5_clr_no_match_out", out, 0);

`ifdef SEQ_DET_MASK_EN
        // Test 6: mask makes middle bits don't-care
        do_reset();
        overlap = 1'b0;
        do_load(4'b1001, 4'b1001, 1'b0, 1'b0);
        send(1'b1); send(1'b1); send(1'b0); send(1'b1);
        check("t6_mask_match", out, 1);
        send(1'b1); send(1'b0); send(1'b0); send(1'b0);
        check("t6_mask_nomatch", out, 0);
        check("t6_cnt", match_count, 1);
        mask_in = '1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial sequence detector; successor to the fixed 3-bit-state hard-coded detectors. Pattern length is set by parameter, the pattern value is loaded at run time, and overlapping or non-overlapping detection is selected by a port. Adds an input-valid qualifier, a registered match pulse and a saturating match counter. Sits on a serial bit stream that feeds GE-evaluated detector testbenches and control logic.

Parameters:
PAT_W, 4, pattern length in bits (legal 2..32); the first-received bit is compared with pattern[PAT_W-1].
CNT_W, 8, width of the saturating match counter (legal 1..32).

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high; clears all state
i  input  1  serial data bit, sampled when in_valid=1
in_valid  input  1  qualifies i; no shift when 0
load  input  1  latch pattern_in into pattern register, flush history
pattern_in  input  PAT_W  new pattern value, sampled when load=1
overlap  input  1  1=overlapping detection, 0=non-overlapping
count_clr  input  1  clears match_count
out  output  1  registered one-cycle match pulse
match_count  output  CNT_W  number of matches since reset/count_clr, saturating
armed  output  1  1 when history holds PAT_W valid bits

Behaviour:
- Reset (synchronous, active-high) sets: history=0, fill=0, pattern register=0, out=0, match_count=0, armed=0. Reset dominates every other input in the same cycle.
- Internal state: history[PAT_W-1:0] shift register; fill counter 0..PAT_W, width $clog2(PAT_W+1), saturating at PAT_W. Two implied states:
  - FILLING: fill<PAT_W.
  - ARMED: fill==PAT_W.
  - armed = (fill==PAT_W), driven from a register.
- Shift on in_valid=1 and load=0: hist_n = {history[PAT_W-2:0], i}; fill_n = min(fill+1, PAT_W).
- Match condition, evaluated on the shifting cycle: fill_n==PAT_W and hist_n==pattern register.
- out is 1 in the cycle after the completing bit is sampled (latency 1). out is 0 in every other cycle, including cycles with in_valid=0.
- After a match:
  - overlap=1: history and fill are kept, so the next match may share bits.
  - overlap=0: fill is forced to 0 (history value is don't-care). The next match needs PAT_W fresh bits.
- overlap is sampled each cycle. Changing it mid-stream affects only matches that occur after the change.
- load=1:
  - Pattern register <= pattern_in; fill <= 0; out <= 0.
  - A bit presented in the same cycle with in_valid=1 is discarded.
  - match_count is unaffected.
- match_count:
  - Increments by 1 on each match.
  - Saturates at 2^CNT_W-1 and holds; no wrap.
  - count_clr=1 with no match in the same cycle: count <= 0.
  - count_clr=1 with a match in the same cycle: count <= 1.
- Pattern register value 0 is legal. With pattern 0, a run of zeros after reset produces matches.

Optional Feature:
SEQ_DET_MASK_EN:
- Defined: adds input port mask_in [PAT_W-1:0], latched together with pattern_in on load. The match condition becomes ((hist_n ^ pattern) & mask)==0, so mask bits at 0 are don't-care. Reset value of the mask register is all-ones.
- Undefined: no mask_in port and no mask register; exact compare as above. The implementation must be equivalent to an all-ones mask.

Test Plan:
1. PAT_W=4, load 4'b1011, overlap=1, stream 1,0,1,1,0,1,1 (in_valid=1 throughout) -> out=1 the cycle after bit 4 and the cycle after bit 7; match_count=2.
2. Same stream with overlap=0 -> out=1 only after bit 4; match_count=1; armed drops to 0 the cycle after the match and returns to 1 after 4 more bits.
3. Pattern 1011; stream 1,0 with in_valid=1, then 3 idle cycles with in_valid=0 and i toggling, then 1,1 with in_valid=1 -> exactly one match, out=1 after the final 1; idle cycles are ignored.
4. Assert reset after the bit sequence 1,0,1, then send 1 -> no match; out=0, fill=1, match_count=0, pattern register=0.
5. CNT_W=2, overlap=1, pattern 4'b1111, stream of 10 ones -> match_count goes 1,2,3 and holds at 3. count_clr in the same cycle as the next match -> match_count=1.
6. Mask build (SEQ_DET_MASK_EN), pattern 4'b1001, mask 4'b1001, stream 1,1,0,1 -> match; stream 1,0,0,0 -> no match.
